// File: rtl/uart_reg_arbiter.sv
// Queues UART-decoded register writes in a small FIFO and shares a single-port register
// array between that write queue and a core read port through a round-robin arbiter.
module uart_reg_arbiter #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        uart_addr,
    input  logic [DATA_W-1:0]        uart_data,
    input  logic                     uart_ready,
    input  logic                     rd_req,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_gnt,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     wr_strobe,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    localparam int unsigned PtrW    = $clog2(DEPTH);
    localparam int unsigned NumRegs = 2 ** ADDR_W;
    localparam logic [PtrW:0]   CntOne  = 1;
    localparam logic [PtrW:0]   CntFull = DEPTH[PtrW:0];
    localparam logic [PtrW-1:0] PtrOne  = 1;

    logic              sync_s1_q, sync_s2_q, hist_q;
    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]     count_q, count_d;
    logic [DATA_W-1:0] regs_q [NumRegs];
    logic              last_w_q, last_w_d;
    logic              overflow_q, overflow_d;
    logic              rd_valid_q, wr_strobe_q;
    logic [DATA_W-1:0] rd_data_q, wr_data_q;
    logic [ADDR_W-1:0] wr_addr_q;

    logic push, full, w_req, w_gnt, r_gnt, push_ok, drop;

    assign push    = sync_s2_q & ~hist_q;
    assign full    = (count_q == CntFull);
    assign w_req   = (count_q != '0);
    // On contention, grant whichever side did not win last time.
    assign w_gnt   = w_req & (~rd_req | ~last_w_q);
    assign r_gnt   = rd_req & ~w_gnt;
    assign push_ok = push & (~full | w_gnt);
    assign drop    = push & full & ~w_gnt;

    always_comb begin
        count_d = count_q;
        if (push_ok && !w_gnt) begin
            count_d = count_q + CntOne;
        end else if (!push_ok && w_gnt) begin
            count_d = count_q - CntOne;
        end
    end

    always_comb begin
        last_w_d = last_w_q;
        if (w_gnt) begin
            last_w_d = 1'b1;
        end else if (r_gnt) begin
            last_w_d = 1'b0;
        end
    end

    assign overflow_d = (overflow_q & ~overflow_clr) | drop;

    // Synchroniser flops reset high so a ready level held across reset is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_s1_q   <= 1'b1;
            sync_s2_q   <= 1'b1;
            hist_q      <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_w_q    <= 1'b0;
            overflow_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            sync_s1_q   <= uart_ready;
            sync_s2_q   <= sync_s1_q;
            hist_q      <= sync_s2_q;
            count_q     <= count_d;
            last_w_q    <= last_w_d;
            overflow_q  <= overflow_d;
            rd_valid_q  <= r_gnt;
            wr_strobe_q <= w_gnt;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (w_gnt) begin
                rd_ptr_q                        <= rd_ptr_q + PtrOne;
                regs_q[fifo_addr_q[rd_ptr_q]]   <= fifo_data_q[rd_ptr_q];
                wr_addr_q                       <= fifo_addr_q[rd_ptr_q];
                wr_data_q                       <= fifo_data_q[rd_ptr_q];
            end
            if (r_gnt) begin
                rd_data_q <= regs_q[rd_addr];
            end
        end
    end

    // Storage only; emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_addr_q[wr_ptr_q] <= uart_addr;
            fifo_data_q[wr_ptr_q] <= uart_data;
        end
    end

    assign rd_gnt     = r_gnt;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_reg_arbiter.sv
// Scoreboard bench for uart_reg_arbiter: expected writes and reads are queued at stimulus
// or grant time and compared when wr_strobe / rd_valid appear.
module tb_uart_reg_arbiter;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned CntW   = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] uart_addr;
    logic [DATA_W-1:0] uart_data;
    logic              uart_ready;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [CntW-1:0]   fifo_count;
    logic              overflow;
    logic              overflow_clr;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W+DATA_W-1:0] exp_wr [$];
    logic [DATA_W-1:0]        exp_rd [$];
    logic [DATA_W-1:0]        model [2**ADDR_W];

    uart_reg_arbiter #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_addr    (uart_addr),
        .uart_data    (uart_data),
        .uart_ready   (uart_ready),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_gnt       (rd_gnt),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .wr_strobe    (wr_strobe),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input bit accept);
        uart_addr = a;
        uart_data = d;
        repeat (5) tick();
        uart_ready = 1'b1;
        if (accept) exp_wr.push_back({a, d});
        repeat (5) tick();
        uart_ready = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        bit got;
        got     = 1'b0;
        rd_addr = a;
        rd_req  = 1'b1;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (rd_gnt) got = 1'b1;
        end
        check_eq("rd_gnt_wait", 32'(got), 32'd1);
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    // Scoreboard monitor: compare completions, then record new read grants.
    initial begin
        logic [ADDR_W+DATA_W-1:0] e;
        for (int i = 0; i < 2**ADDR_W; i++) model[i] = '0;
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                if (exp_rd.size() == 0) check_eq("rd_valid_spurious", 32'(rd_valid), 32'd0);
                else check_eq("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
            end
            if (wr_strobe === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    check_eq("wr_strobe_spurious", 32'(wr_strobe), 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    check_eq("wr_addr", 32'(wr_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                    check_eq("wr_data", 32'(wr_data), 32'(e[DATA_W-1:0]));
                    model[e[ADDR_W+DATA_W-1:DATA_W]] = e[DATA_W-1:0];
                end
            end
            if (reset === 1'b1) begin
                exp_wr.delete();
                exp_rd.delete();
                for (int i = 0; i < 2**ADDR_W; i++) model[i] = '0;
            end else if (rd_gnt === 1'b1) begin
                exp_rd.push_back(model[rd_addr]);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] pat;
        reset        = 1'b1;
        uart_ready   = 1'b0;
        uart_addr    = '0;
        uart_data    = '0;
        rd_req       = 1'b0;
        rd_addr      = '0;
        overflow_clr = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        // Reset state
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_eq("rst_wr_data", 32'(wr_data), 32'd0);
        check_eq("rst_fifo_count", 32'(fifo_count), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_rd_gnt", 32'(rd_gnt), 32'd0);

        // Contention: two queued writes vs. a held read request -> W,R,W,R
        force dut.w_req = 1'b0;
        send_msg(5'h05, 4'h6, 1'b1);
        send_msg(5'h06, 4'h9, 1'b1);
        check_eq("cont_count2", 32'(fifo_count), 32'd2);
        release dut.w_req;
        rd_addr = 5'h05;
        rd_req  = 1'b1;
        pat     = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("cont_rd_gnt", 32'(rd_gnt), 32'(pat[i]));
            tick();
        end
        rd_req = 1'b0;
        tick();
        check_eq("cont_count0", 32'(fifo_count), 32'd0);

        // Single message: exact commit latency
        uart_addr = 5'h03;
        uart_data = 4'hA;
        repeat (5) tick();
        uart_ready = 1'b1;
        exp_wr.push_back({5'h03, 4'hA});
        repeat (3) tick();
        check_eq("single_early_strobe", 32'(wr_strobe), 32'd0);
        check_eq("single_count1", 32'(fifo_count), 32'd1);
        tick();
        check_eq("single_strobe", 32'(wr_strobe), 32'd1);
        check_eq("single_wr_addr", 32'(wr_addr), 32'h03);
        check_eq("single_wr_data", 32'(wr_data), 32'hA);
        tick();
        check_eq("single_strobe_off", 32'(wr_strobe), 32'd0);
        check_eq("single_wr_hold", 32'(wr_data), 32'hA);
        uart_ready = 1'b0;
        do_read(5'h03);
        check_eq("single_rd_hold", 32'(rd_data), 32'hA);

        // Wrap: 2*DEPTH+1 writes, then read each back
        for (int i = 0; i < 2*DEPTH+1; i++) send_msg(5'(16 + i), 4'(15 - i), 1'b1);
        for (int i = 0; i < 2*DEPTH+1; i++) do_read(5'(16 + i));

        // Five pushes with a continuous competing read: writes still drain
        rd_addr = 5'h1F;
        rd_req  = 1'b1;
        for (int i = 0; i < 5; i++) send_msg(5'(8 + i), 4'(i + 3), 1'b1);
        rd_req = 1'b0;
        repeat (3) tick();
        check_eq("ovf_drain_overflow", 32'(overflow), 32'd0);
        check_eq("ovf_drain_count", 32'(fifo_count), 32'd0);

        // Writes blocked: fifth push dropped
        force dut.w_req = 1'b0;
        for (int i = 0; i < 4; i++) send_msg(5'(i), 4'(i + 7), 1'b1);
        check_eq("full_count", 32'(fifo_count), 32'd4);
        check_eq("full_no_overflow", 32'(overflow), 32'd0);
        send_msg(5'h1E, 4'h5, 1'b0);
        check_eq("drop_overflow", 32'(overflow), 32'd1);
        check_eq("drop_count", 32'(fifo_count), 32'd4);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check_eq("ovf_clr", 32'(overflow), 32'd0);

        // Full with push and pop in the same cycle
        uart_addr = 5'h1D;
        uart_data = 4'hC;
        repeat (5) tick();
        uart_ready = 1'b1;
        exp_wr.push_back({5'h1D, 4'hC});
        repeat (2) tick();
        release dut.w_req;
        tick();
        check_eq("pp_count", 32'(fifo_count), 32'd4);
        check_eq("pp_overflow", 32'(overflow), 32'd0);
        check_eq("pp_strobe", 32'(wr_strobe), 32'd1);
        repeat (6) tick();
        uart_ready = 1'b0;
        check_eq("pp_drained", 32'(fifo_count), 32'd0);
        do_read(5'h1D);

        // Reset mid-operation with three queued writes and a read granted
        force dut.w_req = 1'b0;
        for (int i = 0; i < 3; i++) send_msg(5'(20 + i), 4'(i + 1), 1'b1);
        check_eq("mid_count3", 32'(fifo_count), 32'd3);
        rd_addr = 5'h03;
        rd_req  = 1'b1;
        reset   = 1'b1;
        @(negedge clk);
        check_eq("mid_rd_gnt", 32'(rd_gnt), 32'd1);
        tick();
        reset  = 1'b0;
        rd_req = 1'b0;
        release dut.w_req;
        check_eq("mid_count0", 32'(fifo_count), 32'd0);
        check_eq("mid_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq("mid_no_strobe", 32'(wr_strobe), 32'd0);
            check_eq("mid_no_valid", 32'(rd_valid), 32'd0);
            tick();
        end
        for (int i = 0; i < 2**ADDR_W; i++) do_read(5'(i));

        // Ready held high across reset release: not an edge
        uart_addr  = 5'h11;
        uart_data  = 4'h4;
        uart_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (8) tick();
        check_eq("rst_ready_count", 32'(fifo_count), 32'd0);
        uart_ready = 1'b0;
        repeat (3) tick();
        check_eq("rst_ready_count2", 32'(fifo_count), 32'd0);
        do_read(5'h11);

        // Recovery after reset
        send_msg(5'h07, 4'h3, 1'b1);
        repeat (3) tick();
        do_read(5'h07);

        repeat (4) tick();
        check_eq("exp_wr_empty", 32'(exp_wr.size()), 32'd0);
        check_eq("exp_rd_empty", 32'(exp_rd.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
